// File: rtl/serial_demux_1_to_n.sv
// serial_demux_1_to_n: bit-serial deserializer with a one-word skid buffer on a valid/ready output.
module serial_demux_1_to_n #(
    parameter int N = 8,
    localparam int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_bit,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          frame_clr,
    output logic [SW-1:0] sel,
    output logic [N-1:0]  out_word,
    output logic          out_valid,
    input  logic          out_ready
);
    typedef enum logic {COLLECT, HOLD} state_t;
    state_t r_state;
    state_t w_state_nxt;
    logic [N-1:0]  r_shd;
    logic [N-1:0]  r_out_word;
    logic [SW-1:0] r_sel;
    logic          r_out_valid;
    logic          w_accept;
    logic          w_drain;
    logic          w_last;
    logic          w_complete;
    assign w_accept   = in_valid && in_ready && !frame_clr;
    assign w_drain    = r_out_valid && out_ready;
    assign w_last     = r_sel == SW'(N - 1);
    assign w_complete = w_accept && w_last;
    always_ff @(posedge clk) begin
        if (rst) r_state <= COLLECT;
        else r_state <= w_state_nxt;
    end
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == COLLECT) w_state_nxt = (w_complete && r_out_valid && !out_ready) ? HOLD : COLLECT;
        else w_state_nxt = w_drain ? COLLECT : HOLD;
    end
    always_comb begin
        in_ready = (r_state == COLLECT) && !rst;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shd       <= '0;
            r_sel       <= '0;
            r_out_word  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (r_state == COLLECT && frame_clr) r_sel <= '0;
            else if (w_accept) begin
                r_shd[r_sel] <= in_bit;
                r_sel        <= w_last ? '0 : r_sel + SW'(1);
            end
            if (w_complete && (!r_out_valid || w_drain)) begin
                r_out_word  <= {in_bit, r_shd[N-2:0]};
                r_out_valid <= 1'b1;
            end else if (r_state == HOLD && w_drain) r_out_word <= r_shd;
            else if (w_drain) r_out_valid <= 1'b0;
        end
    end
    assign sel       = r_sel;
    assign out_word  = r_out_word;
    assign out_valid = r_out_valid;
endmodule

// File: tb/tb_serial_demux_1_to_n.sv
// tb_serial_demux_1_to_n: randomized and directed checks against a word-queue reference model.
module tb_serial_demux_1_to_n;
    localparam int N = 8;
    logic clk = 0;
    logic rst = 1;
    logic in_bit = 0, in_valid = 0, frame_clr = 0, out_ready = 0;
    logic in_ready, out_valid;
    logic [2:0] sel;
    logic [7:0] out_word;
    logic n4_bit = 0, n4_valid = 0, n4_clr = 0, n4_ordy = 1;
    logic n4_in_ready, n4_out_valid;
    logic [1:0] n4_sel;
    logic [3:0] n4_word;
    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];
    logic [7:0] part = '0;
    int cnt = 0;

    always #5 clk = ~clk;

    serial_demux_1_to_n #(.N(8)) dut (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
        .frame_clr(frame_clr), .sel(sel), .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready)
    );

    serial_demux_1_to_n #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .in_bit(n4_bit), .in_valid(n4_valid), .in_ready(n4_in_ready),
        .frame_clr(n4_clr), .sel(n4_sel), .out_word(n4_word), .out_valid(n4_out_valid), .out_ready(n4_ordy)
    );

    // Model: completed words wait in a queue of depth 2; the head is what the port presents.
    task automatic step(input logic v, input logic b, input logic fc, input logic ordy, input string tag);
        bit acc, drn, done;
        in_valid = v; in_bit = b; frame_clr = fc; out_ready = ordy;
        acc = v && q.size() < 2 && !fc;
        drn = q.size() > 0 && ordy;
        done = 0;
        @(posedge clk);
        if (fc && q.size() < 2) cnt = 0;
        else if (acc) begin
            part[cnt] = b;
            cnt++;
            if (cnt == N) begin done = 1; cnt = 0; end
        end
        if (drn) void'(q.pop_front());
        if (done) q.push_back(part);
        #1;
        checks += 3;
        if (sel !== 3'(cnt)) begin errors++; $display("FAIL %s sel got %0d exp %0d", tag, sel, cnt); end
        if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL %s out_valid got %b exp %b", tag, out_valid, q.size() > 0); end
        if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL %s in_ready got %b exp %b", tag, in_ready, q.size() < 2); end
        if (q.size() > 0) begin
            checks++;
            if (out_word !== q[0]) begin errors++; $display("FAIL %s out_word got %h exp %h", tag, out_word, q[0]); end
        end
    endtask

    task automatic send_word(input logic [7:0] w, input logic ordy, input string tag);
        for (int i = 0; i < N; i++) step(1'b1, w[i], 1'b0, ordy, tag);
    endtask

    task automatic expect_word(input logic [7:0] w, input string tag);
        checks++;
        if (out_valid !== 1'b1 || out_word !== w) begin
            errors++;
            $display("FAIL %s word got v=%b %h exp v=1 %h", tag, out_valid, out_word, w);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1; in_valid = 0; frame_clr = 0;
        repeat (cycles) @(posedge clk);
        #1;
        q.delete(); cnt = 0;
        checks += 4;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready_during got %b exp 0", in_ready); end
        if (sel !== 3'd0) begin errors++; $display("FAIL reset sel got %0d exp 0", sel); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
        if (out_word !== 8'h00) begin errors++; $display("FAIL reset out_word got %h exp 00", out_word); end
        rst = 0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready_after got %b exp 1", in_ready); end
    endtask

    task automatic test_reset();
        do_reset(2);
    endtask

    task automatic test_single_word();
        send_word(8'hB3, 1'b1, "single");
        expect_word(8'hB3, "single");
        step(1'b0, 1'b0, 1'b0, 1'b1, "single_idle");
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        send_word(8'hB3, 1'b1, "b2b");
        expect_word(8'hB3, "b2b_first");
        for (int i = 0; i < N; i++) begin
            step(1'b1, bit'(8'h5A >> i), 1'b0, 1'b1, "b2b");
            if (out_valid) pulses++;
        end
        expect_word(8'h5A, "b2b_second");
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL b2b_spacing pulses got %0d exp 1", pulses); end
        step(1'b0, 1'b0, 1'b0, 1'b1, "b2b_idle");
    endtask

    task automatic test_backpressure();
        send_word(8'hB3, 1'b0, "bp");
        send_word(8'h5A, 1'b0, "bp");
        repeat (3) step(1'b1, 1'($urandom), 1'b0, 1'b0, "bp_extra");
        expect_word(8'hB3, "bp_held");
        checks += 2;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold in_ready got %b exp 0", in_ready); end
        if (sel !== 3'd0) begin errors++; $display("FAIL bp_hold sel got %0d exp 0", sel); end
        step(1'b0, 1'b0, 1'b0, 1'b1, "bp_drain1");
        expect_word(8'h5A, "bp_second");
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release in_ready got %b exp 1", in_ready); end
        step(1'b0, 1'b0, 1'b0, 1'b1, "bp_drain2");
    endtask

    task automatic test_frame_clr();
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1, "clr_pre");
        step(1'b1, 1'b1, 1'b1, 1'b1, "clr");
        checks++;
        if (sel !== 3'd0) begin errors++; $display("FAIL clr sel got %0d exp 0", sel); end
        send_word(8'hB3, 1'b1, "clr_word");
        expect_word(8'hB3, "clr_word");
        step(1'b0, 1'b0, 1'b0, 1'b1, "clr_idle");
    endtask

    task automatic test_reset_mid_word();
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b0, 1'b1, "rst_mid_pre");
        do_reset(1);
        send_word(8'h96, 1'b1, "rst_mid_word");
        expect_word(8'h96, "rst_mid_word");
        step(1'b0, 1'b0, 1'b0, 1'b1, "rst_mid_idle");
    endtask

    task automatic test_n4();
        logic [3:0] w = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            n4_valid = 1; n4_bit = w[i];
            @(posedge clk);
            #1;
            checks++;
            if (n4_sel !== 2'((i + 1) % 4)) begin errors++; $display("FAIL n4_sel got %0d exp %0d", n4_sel, (i + 1) % 4); end
        end
        n4_valid = 0;
        checks++;
        if (n4_out_valid !== 1'b1 || n4_word !== 4'h9) begin
            errors++;
            $display("FAIL n4_word got v=%b %h exp v=1 9", n4_out_valid, n4_word);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset(1);
            else step(($urandom % 4) != 0, 1'($urandom), ($urandom % 25) == 0, ($urandom % 3) != 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_frame_clr();
        test_reset_mid_word();
        test_n4();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
